// File: rtl/counter_sequencer.sv
// Prescaled terminal-count timer sequencer for the up-counter datapath.
// One-shot or periodic; pause/stop control and a one-cycle done pulse.
module counter_sequencer #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_periodic,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               per_q, per_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_acc;
  logic               run_step;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    limit_d  = limit_q;
    presc_d  = presc_q;
    per_d    = per_q;
    done_d   = 1'b0;
    run_step = 1'b0;
    cfg_acc  = cfg_valid && ready_q;

    unique case (state_q)
      S_IDLE, S_EXPIRED: begin
        if (cfg_acc) begin
          limit_d = cfg_limit;
          presc_d = cfg_presc;
          per_d   = cfg_periodic;
        end
        if (state_q == S_EXPIRED && stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pcnt_d  = '0;
        end else if (start && !cfg_acc) begin
          state_d = S_RUN;
          count_d = '0;
          pcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pcnt_d  = '0;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else begin
          run_step = 1'b1;
        end
      end
      S_PAUSED: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pcnt_d  = '0;
        end else if (!pause) begin
          // Resume edge counts as a run cycle so only paused cycles add delay.
          state_d  = S_RUN;
          run_step = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (run_step) begin
      if (pcnt_q != presc_q) begin
        pcnt_d = pcnt_q + 1'b1;
      end else begin
        pcnt_d = '0;
        if (count_q != limit_q) begin
          count_d = count_q + 1'b1;
        end else begin
          done_d = 1'b1;
          if (per_q) count_d = '0;
          else       state_d = S_EXPIRED;
        end
      end
    end

    ready_d = (state_d == S_IDLE) || (state_d == S_EXPIRED);
    busy_d  = (state_d == S_RUN)  || (state_d == S_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      pcnt_q  <= '0;
      limit_q <= '0;
      presc_q <= '0;
      per_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      limit_q <= limit_d;
      presc_q <= presc_d;
      per_q   <= per_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cfg_ready = ready_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: per-cycle expectations go through
// a scoreboard queue and are checked #1 after each rising edge.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_limit;
  logic [3:0] cfg_presc;
  logic       cfg_periodic;
  logic       start;
  logic       pause;
  logic       stop;
  logic [3:0] count;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_limit   (cfg_limit),
    .cfg_presc   (cfg_presc),
    .cfg_periodic(cfg_periodic),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tbl[6]   = '{0, 1, 1, 2, 2, 0};

  task automatic chk(string tag, string f, logic [3:0] got, logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, got, exp);
    end
  endtask

  task automatic step(string tag, int c, bit b, bit d, bit r);
    exp_t e;
    e.tag  = tag;
    e.cnt  = 4'(c);
    e.busy = b;
    e.done = d;
    e.rdy  = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "count", count, e.cnt);
    chk(e.tag, "busy", {3'b0, busy}, {3'b0, e.busy});
    chk(e.tag, "done", {3'b0, done}, {3'b0, e.done});
    chk(e.tag, "ready", {3'b0, cfg_ready}, {3'b0, e.rdy});
  endtask

  task automatic cfg(int l, int p, bit per);
    cfg_valid    = 1'b1;
    cfg_limit    = 4'(l);
    cfg_presc    = 4'(p);
    cfg_periodic = per;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_valid = 1'b0; cfg_limit = '0; cfg_presc = '0;
    cfg_periodic = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;

    step("rst", 0, 0, 0, 1);
    step("rst", 0, 0, 0, 1);
    rst = 1'b1;

    // one-shot limit 3
    cfg(3, 0, 0);
    step("os_cfg", 0, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    step("os_start", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) step("os_cnt", i, 1, 0, 0);
    step("os_done", 3, 0, 1, 1);
    step("os_hold", 3, 0, 0, 1);
    step("os_hold", 3, 0, 0, 1);

    // pause for 5 cycles at count 1
    start = 1'b1;
    step("pz_start", 0, 1, 0, 0);
    start = 1'b0;
    step("pz_c1", 1, 1, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) step("pz_frozen", 1, 1, 0, 0);
    pause = 1'b0;
    step("pz_c2", 2, 1, 0, 0);
    step("pz_c3", 3, 1, 0, 0);
    step("pz_done", 3, 0, 1, 1);

    // config lockout during RUN, accepted after EXPIRED
    start = 1'b1;
    step("lk_start", 0, 1, 0, 0);
    start = 1'b0;
    cfg(7, 0, 0);
    for (int i = 1; i <= 3; i++) step("lk_run", i, 1, 0, 0);
    step("lk_done", 3, 0, 1, 1);
    step("lk_acc", 3, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    step("l7_start", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 7; i++) step("l7_cnt", i, 1, 0, 0);
    step("l7_done", 7, 0, 1, 1);

    // periodic limit 2 presc 1
    cfg(2, 1, 1);
    step("pr_cfg", 7, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    step("pr_start", 0, 1, 0, 0);
    start = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 6; i++)
        step("pr_seq", tbl[i], 1, i == 5, 0);

    // mid-run reset
    step("rs_c0", 0, 1, 0, 0);
    step("rs_c1", 1, 1, 0, 0);
    rst = 1'b0;
    step("rs_apply", 0, 0, 0, 1);
    rst = 1'b1;
    step("rs_idle", 0, 0, 0, 1);
    start = 1'b1;
    step("rs_start", 0, 1, 0, 0);
    start = 1'b0;
    step("rs_lim0", 0, 0, 1, 1);

    // stop on terminal edge
    cfg(1, 0, 1);
    step("st_cfg", 0, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    step("st_start", 0, 1, 0, 0);
    start = 1'b0;
    step("st_c1", 1, 1, 0, 0);
    stop = 1'b1;
    step("st_term", 0, 0, 0, 1);
    stop = 1'b0;

    // start with cfg in same cycle: config only
    cfg(2, 0, 0); start = 1'b1;
    step("cs_both", 0, 0, 0, 1);
    cfg_valid = 1'b0;
    step("cs_start", 0, 1, 0, 0);
    start = 1'b0;
    step("cs_c1", 1, 1, 0, 0);
    step("cs_c2", 2, 1, 0, 0);
    step("cs_done", 2, 0, 1, 1);

    // limit 0 presc 0 periodic: done every cycle
    cfg(0, 0, 1);
    step("z_cfg", 2, 0, 0, 1);
    cfg_valid = 1'b0; start = 1'b1;
    step("z_start", 0, 1, 0, 0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) step("z_every", 0, 1, 1, 0);
    stop = 1'b1;
    step("z_stop", 0, 0, 0, 1);
    stop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
